// File: rtl/mips32_issue_ctrl.sv
// mips32_issue_ctrl: in-order issue control for a 5-stage MIPS32 pipeline.
// Holds instructions in ID while a source register is still being produced
// by the instruction in EX or MEM, waits in BR_WAIT until an issued branch
// resolves, and stops issuing after HLT.
module mips32_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    output logic        id_ready,
    output logic        issue_valid,
    input  logic        br_done,
    input  logic        br_taken,
    output logic        flush,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, BR_WAIT, HALT} state_t;

    state_t      state, state_nxt;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [4:0]  dst;
    logic        dst_en, use_rs, use_rt, is_br, is_hlt;
    logic        hazard;

    // Scoreboard slots: _p0 is the instruction in EX, _p1 the one in MEM
    logic        vld_p0, vld_p1;
    logic [4:0]  dst_p0, dst_p1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic src_hit(input logic [4:0] r,
                                     input logic v0, input logic [4:0] d0,
                                     input logic v1, input logic [4:0] d1);
        return (r != 5'd0) && ((v0 && d0 == r) || (v1 && d1 == r));
    endfunction

    assign op = id_instr[31:26];
    assign rs = id_instr[25:21];
    assign rt = id_instr[20:16];
    assign rd = id_instr[15:11];

    // Opcode classification: destination and which source fields are read
    always_comb begin
        dst    = rd;
        dst_en = 1'b0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        is_br  = 1'b0;
        is_hlt = 1'b0;
        if (op <= 6'b000101) begin
            dst_en = 1'b1;
            use_rs = 1'b1;
            use_rt = 1'b1;
        end else if (op == 6'b001000 || (op >= 6'b001010 && op <= 6'b001100)) begin
            dst    = rt;
            dst_en = 1'b1;
            use_rs = 1'b1;
        end else if (op == 6'b001001) begin
            use_rs = 1'b1;
            use_rt = 1'b1;
        end else if (op == 6'b001101 || op == 6'b001110) begin
            use_rs = 1'b1;
            is_br  = 1'b1;
        end else if (op == 6'b111111) begin
            is_hlt = 1'b1;
        end
    end

    assign hazard = id_valid &&
                    ((use_rs && src_hit(rs, vld_p0, dst_p0, vld_p1, dst_p1)) ||
                     (use_rt && src_hit(rt, vld_p0, dst_p0, vld_p1, dst_p1)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; rst_n gate keeps id_ready low while reset is held
    always_comb begin
        state_nxt   = state;
        id_ready    = 1'b0;
        issue_valid = 1'b0;
        flush       = 1'b0;
        halted      = 1'b0;
        case (state)
            RUN: begin
                if (rst_n && id_valid && !hazard) begin
                    id_ready    = 1'b1;
                    issue_valid = 1'b1;
                    if (is_br)       state_nxt = BR_WAIT;
                    else if (is_hlt) state_nxt = HALT;
                end
            end
            BR_WAIT: begin
                if (br_done) begin
                    flush     = br_taken;
                    state_nxt = RUN;
                end
            end
            HALT: halted = 1'b1;
            default: state_nxt = RUN;
        endcase
    end

    // ID -> EX -> MEM slot valids; bubbles and R0 writers leave the slot empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= issue_valid && dst_en && (dst != 5'd0);
            vld_p1 <= vld_p0;
        end
    end

    // ID -> EX -> MEM slot destinations, only meaningful under their valids
    always_ff @(posedge clk) begin
        dst_p0 <= dst;
        dst_p1 <= dst_p0;
    end

    // Hazard-bubble counter, RUN cycles only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      stall_cnt <= 16'd0;
        else if (state == RUN && hazard) stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_mips32_issue_ctrl.sv
// tb_mips32_issue_ctrl: directed and random stimulus against a cycle-level
// model that tracks, per register, the first cycle its value may be read.
module tb_mips32_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = 32'h0;
    logic        id_ready, issue_valid, flush, halted;
    logic        br_done = 1'b0, br_taken = 1'b0;
    logic [15:0] stall_cnt;

    mips32_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_ready(id_ready), .issue_valid(issue_valid), .br_done(br_done),
        .br_taken(br_taken), .flush(flush), .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        iv;
        logic        fl;
        logic        hl;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: mode 0=RUN 1=BR_WAIT 2=HALT; avail[r] = first cycle r is readable
    int   avail[32];
    int   cyc = 0;
    int   mode = 0;
    int   stall_m = 0;
    bit   last_issue = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cycle-check: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit v, input logic [31:0] ins,
                        input bit bd, input bit bt, input bit rst);
        exp_t e;
        int   op, rs, rt, rd, dst;
        bit   urs, urt, br, hlt, haz;
        @(posedge clk);
        #1;
        id_valid = v;
        id_instr = ins;
        br_done  = bd;
        br_taken = bt;
        rst_n    = !rst;
        if (rst) begin
            e = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
            mode = 0;
            stall_m = 0;
            for (int i = 0; i < 32; i++) avail[i] = 0;
            last_issue = 0;
        end else begin
            op = int'(ins[31:26]);
            rs = int'(ins[25:21]);
            rt = int'(ins[20:16]);
            rd = int'(ins[15:11]);
            dst = 0; urs = 0; urt = 0; br = 0; hlt = 0;
            if (op <= 5) begin dst = rd; urs = 1; urt = 1; end
            else if (op == 8 || (op >= 10 && op <= 12)) begin dst = rt; urs = 1; end
            else if (op == 9) begin urs = 1; urt = 1; end
            else if (op == 13 || op == 14) begin urs = 1; br = 1; end
            else if (op == 63) hlt = 1;
            haz = v && ((urs && rs != 0 && cyc < avail[rs]) ||
                        (urt && rt != 0 && cyc < avail[rt]));
            e.rdy = (mode == 0) && v && !haz;
            e.iv  = e.rdy;
            e.fl  = (mode == 1) && bd && bt;
            e.hl  = (mode == 2);
            e.sc  = 16'(stall_m);
            last_issue = e.rdy;
            if (mode == 0 && haz && stall_m < 65535) stall_m++;
            if (e.rdy) begin
                if (dst != 0) avail[dst] = cyc + 3;
                if (br) mode = 1;
                else if (hlt) mode = 2;
            end else if (mode == 1 && bd) begin
                mode = 0;
            end
        end
        q.push_back(e);
        cyc++;
    endtask

    // Present an instruction until it is accepted (bounded)
    task automatic issue(input logic [31:0] ins);
        int n = 0;
        do begin
            step(1, ins, 0, 0, 0);
            n++;
        end while (!last_issue && n < 8);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops[9];
        logic [5:0] op;
        int k;
        ops = '{6'd0, 6'd3, 6'd10, 6'd8, 6'd9, 6'd13, 6'd14, 6'd63, 6'd21};
        k = $urandom_range(0, 99);
        if (k < 2)        op = ops[7];
        else if (k < 10)  op = ops[5 + (k & 1)];
        else              op = ops[$urandom_range(0, 4) + ((k % 7 == 0) ? 4 : 0)];
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom)};
    endfunction

    // Monitor: compare each presented cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("id_ready",    int'(id_ready),    int'(e.rdy));
                chk("issue_valid", int'(issue_valid), int'(e.iv));
                chk("flush",       int'(flush),       int'(e.fl));
                chk("halted",      int'(halted),      int'(e.hl));
                chk("stall_cnt",   int'(stall_cnt),   int'(e.sc));
            end
        end
    end

    initial begin
        int hcnt;
        for (int i = 0; i < 32; i++) avail[i] = 0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // dependent pair: two bubbles
        issue(32'h2801000a);
        issue(32'h00222000);
        step(0, 0, 0, 0, 1);
        // one and two independent instructions between
        issue(32'h2801000a); issue(32'h0ce77800); issue(32'h00222000);
        step(0, 0, 0, 0, 1);
        issue(32'h2801000a); issue(32'h0ce77800); issue(32'h0ce77800); issue(32'h00222000);
        step(0, 0, 0, 0, 1);
        // R0 destination never hazards
        issue(32'h28000005); issue(32'h00002000);
        // taken branch, then not-taken; br_done outside BR_WAIT ignored
        step(0, 0, 1, 1, 0);
        issue(32'h38000000);
        step(1, 32'h0ce77800, 0, 0, 0);
        step(1, 32'h0ce77800, 1, 1, 0);
        step(1, 32'h0ce77800, 0, 0, 0);
        issue(32'h38000000);
        step(1, 32'h0ce77800, 0, 1, 0);
        step(1, 32'h0ce77800, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        // hazard coincides with branch: stall first
        issue(32'h28010001); issue(32'h34200000);
        step(1, 32'h0ce77800, 1, 0, 0);
        // halt, then reset
        issue(32'hfc000000);
        repeat (3) step(1, 32'h0ce77800, 1, 1, 0);
        step(0, 0, 0, 0, 1);
        // reset during a stall discards the hazard
        issue(32'h2801000a);
        step(1, 32'h00222000, 0, 0, 0);
        step(1, 32'h00222000, 0, 0, 1);
        step(1, 32'h00222000, 0, 0, 0);
        // reset during BR_WAIT
        issue(32'h38000000);
        step(1, 32'h0ce77800, 0, 0, 1);
        step(1, 32'h0ce77800, 0, 0, 0);

        hcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            hcnt = (mode == 2) ? hcnt + 1 : 0;
            if (hcnt > 4 || $urandom_range(0, 199) == 0)
                step(0, 0, 0, 0, 1);
            else
                step($urandom_range(0, 9) < 8, rand_instr(),
                     $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 0);
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips32_issue_ctrl.md
MIPS32_ISSUE_CTRL -- requirements
Module: mips32_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port id_valid, input, 1 bit: decoded instruction present in ID.
REQ-004 SHALL have port id_instr, input, 32 bits: instruction in ID (opcode [31:26], rs [25:21], rt [20:16], rd [15:11]).
REQ-005 SHALL have port id_ready, output, 1 bit: instruction accepted (issued) this cycle.
REQ-006 SHALL have port issue_valid, output, 1 bit: non-bubble issued to EX this cycle.
REQ-007 SHALL have port br_done, input, 1 bit: one-cycle pulse, EX resolved outstanding branch.
REQ-008 SHALL have port br_taken, input, 1 bit: qualifies br_done.
REQ-009 SHALL have port flush, output, 1 bit: one-cycle pulse; IF discards its fetched word.
REQ-010 SHALL have port halted, output, 1 bit: HLT issued; no further issue.
REQ-011 SHALL have port stall_cnt, output, 16 bits: saturating count of hazard-bubble cycles.

Function
REQ-012 SHALL classify opcodes: RR 000000-000101 (dst rd; src rs, rt); ADDI/SUBI/SLTI 001010-001100 and LW 001000 (dst rt; src rs); SW 001001 (no dst; src rs, rt); BNEQZ 001101/BEQZ 001110 (no dst; src rs); HLT 111111 (none); others treated as no dst/no src.
REQ-013 SHALL track scoreboard slots EX and MEM, each {valid, dst[4:0]}; each edge MEM<=EX and EX<=dst of instruction issued this cycle, or empty on bubble.
REQ-014 SHALL treat dst=R0 as no dst (never recorded in slots).
REQ-015 SHALL assert hazard when id_valid and any used source register is nonzero and equals a valid EX or MEM slot dst; producer in WB does not hazard (write-before-read).
REQ-016 SHALL assert id_ready=issue_valid=1 combinationally in state RUN with id_valid=1 and no hazard; otherwise both 0.
REQ-017 SHALL, hence, give back-to-back dependent pair exactly 2 bubble cycles; dependence on instruction two ahead gives 1; three ahead gives 0.
REQ-018 SHALL implement states RUN, BR_WAIT, HALT.
REQ-019 RUN: on issue of BNEQZ/BEQZ -> BR_WAIT; on issue of HLT -> HALT; otherwise stay.
REQ-020 BR_WAIT: id_ready=0, slots keep advancing with bubbles; on br_done -> RUN, with flush=1 in that same cycle if br_taken=1.
REQ-021 SHALL ignore br_done outside BR_WAIT; flush SHALL never assert outside BR_WAIT.
REQ-022 HALT: id_ready=0, halted=1, remain until reset; slots drain to empty.
REQ-023 SHALL increment stall_cnt each cycle in RUN with id_valid=1 and hazard=1, saturating at 16'hFFFF; BR_WAIT/HALT cycles not counted.
REQ-024 SHALL, when hazard and branch issue coincide, stall first; branch enters BR_WAIT only when actually issued.

Reset
REQ-025 SHALL on rst_n=0 immediately force state RUN, both slots empty, stall_cnt=0, halted=0, flush=0, id_ready=0 while reset held.
REQ-026 SHALL, on reset asserted mid-stall or in BR_WAIT, discard all tracked hazards; first valid instruction after release issues with no stall.

Verification
REQ-027 ADDI R1,R0,10 (2801000a) then ADD R4,R1,R2 (00222000) held valid -> ADD issues 3rd edge after ADDI, 2 bubbles, stall_cnt=2.
REQ-028 ADDI R1,R0,10; OR R15,R7,R7 (0ce77800); ADD R4,R1,R2 -> 1 bubble before ADD, stall_cnt=1; with two ORs between, stall_cnt=0.
REQ-029 ADDI R0,R0,5 (28000005) then ADD R4,R0,R0 (00002000) -> no stall, stall_cnt=0.
REQ-030 BEQZ issued; br_done=1, br_taken=1 after 2 cycles -> id_ready=0 both cycles, flush pulse 1 cycle, RUN next cycle; repeat with br_taken=0 -> no flush.
REQ-031 HLT (fc000000) issued -> halted=1 next cycle, id_ready=0 indefinitely; rst_n low -> halted=0, stall_cnt=0 asynchronously.
REQ-032 rst_n pulsed low during REQ-027 stall -> after release, ADD issues first cycle, stall_cnt counts from 0.
